uart_cmd_ctrl: RTL and testbench



---
 rtl/uart_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: validates 7-byte command packets from the receive buffer,
// applies them to the DDS configuration registers and returns a 3- or 7-byte response.
module uart_cmd_ctrl #(
  parameter int          RX_PACKET_SIZE = 64,
  parameter int          TX_PACKET_SIZE = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [15:0] DEFAULT_AMPL   = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [8*RX_PACKET_SIZE-1:0] rx_bytes,
  input  logic [15:0]                 rx_count,
  input  logic                        rx_full,
  output logic                        rx_reset,
  output logic [8*TX_PACKET_SIZE-1:0] tx_bytes,
  output logic [15:0]                 tx_size,
  output logic                        tx_go,
  input  logic                        tx_done,
  output logic [31:0]                 freq_word,
  output logic [31:0]                 phase_word,
  output logic [15:0]                 ampl,
  output logic [1:0]                  wave_sel,
  output logic                        cfg_update,
  output logic                        busy,
  output logic [7:0]                  err_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CHECK      = 3'd1;
  localparam logic [2:0] S_APPLY      = 3'd2;
  localparam logic [2:0] S_TX_START   = 3'd3;
  localparam logic [2:0] S_TX_ACK     = 3'd4;
  localparam logic [2:0] S_TX_WAIT    = 3'd5;
  localparam logic [2:0] S_FLUSH      = 3'd6;
  localparam logic [2:0] S_FLUSH_WAIT = 3'd7;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] RESP_BYTE   = 8'h5A;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CHK  = 8'h01;
  localparam logic [7:0] ST_BAD_OP   = 8'h02;
  localparam logic [7:0] ST_BAD_SYNC = 8'h03;
  localparam logic [7:0] OP_FREQ     = 8'h01;
  localparam logic [7:0] OP_PHASE    = 8'h02;
  localparam logic [7:0] OP_AMPL     = 8'h03;
  localparam logic [7:0] OP_WAVE     = 8'h04;
  localparam logic [7:0] OP_READ     = 8'h05;

  logic [2:0]                  state_q, state_d;
  logic [31:0]                 to_cnt_q, to_cnt_d;
  logic [15:0]                 rx_count_q, rx_count_d;
  logic [7:0]                  op_q, op_d;
  logic [31:0]                 data_q, data_d;
  logic [7:0]                  status_q, status_d;
  logic                        rx_reset_q, rx_reset_d;
  logic [8*TX_PACKET_SIZE-1:0] tx_bytes_q, tx_bytes_d;
  logic [15:0]                 tx_size_q, tx_size_d;
  logic                        tx_go_q, tx_go_d;
  logic [31:0]                 freq_q, freq_d;
  logic [31:0]                 phase_q, phase_d;
  logic [15:0]                 ampl_q, ampl_d;
  logic [1:0]                  wave_q, wave_d;
  logic                        cfg_update_q, cfg_update_d;
  logic                        busy_q, busy_d;
  logic [7:0]                  err_q, err_d;

  logic [7:0]  pkt_sync, pkt_op, pkt_chk, pkt_xor, pkt_status;
  logic [31:0] pkt_data;
  logic        err_inc;
  logic        unused_rx_bits;

  assign pkt_sync = rx_bytes[7:0];
  assign pkt_op   = rx_bytes[15:8];
  assign pkt_data = rx_bytes[47:16];
  assign pkt_chk  = rx_bytes[55:48];
  assign pkt_xor  = rx_bytes[7:0] ^ rx_bytes[15:8] ^ rx_bytes[23:16] ^
                    rx_bytes[31:24] ^ rx_bytes[39:32] ^ rx_bytes[47:40];
  // Bytes past the packet are never inspected; the flush discards them.
  assign unused_rx_bits = ^rx_bytes;

  always_comb begin
    if (pkt_sync != SYNC_BYTE)                   pkt_status = ST_BAD_SYNC;
    else if (pkt_chk != pkt_xor)                 pkt_status = ST_BAD_CHK;
    else if (pkt_op == 8'h00 || pkt_op > OP_READ) pkt_status = ST_BAD_OP;
    else                                         pkt_status = ST_OK;
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d      = state_q;
    rx_count_d   = rx_count;
    op_d         = op_q;
    data_d       = data_q;
    status_d     = status_q;
    tx_bytes_d   = tx_bytes_q;
    tx_size_d    = tx_size_q;
    freq_d       = freq_q;
    phase_d      = phase_q;
    ampl_d       = ampl_q;
    wave_d       = wave_q;
    rx_reset_d   = 1'b0;
    tx_go_d      = 1'b0;
    cfg_update_d = 1'b0;
    err_inc      = 1'b0;

    if (state_q != S_IDLE || rx_count == 16'd0 || rx_count != rx_count_q)
      to_cnt_d = '0;
    else
      to_cnt_d = to_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (rx_count >= 16'd7) begin
          state_d = S_CHECK;
        end else if (rx_full || (to_cnt_q >= TIMEOUT_CYCLES && rx_count != 16'd0 &&
                                 rx_count == rx_count_q)) begin
          err_inc = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_CHECK: begin
        op_d     = pkt_op;
        data_d   = pkt_data;
        status_d = pkt_status;
        state_d  = S_APPLY;
      end
      S_APPLY: begin
        rx_reset_d = 1'b1;
        if (status_q == ST_OK) begin
          cfg_update_d = (op_q != OP_READ);
          case (op_q)
            OP_FREQ:  freq_d  = data_q;
            OP_PHASE: phase_d = data_q;
            OP_AMPL:  ampl_d  = data_q[15:0];
            OP_WAVE:  wave_d  = data_q[1:0];
            default:  ;
          endcase
        end else begin
          err_inc = 1'b1;
        end
        tx_bytes_d         = '0;
        tx_bytes_d[7:0]    = RESP_BYTE;
        tx_bytes_d[15:8]   = op_q;
        tx_bytes_d[23:16]  = status_q;
        if (status_q == ST_OK && op_q == OP_READ) begin
          tx_bytes_d[55:24] = freq_q;
          tx_size_d         = 16'd7;
        end else begin
          tx_size_d         = 16'd3;
        end
        state_d = S_TX_START;
      end
      S_TX_START: begin
        tx_go_d = 1'b1;
        state_d = S_TX_ACK;
      end
      S_TX_ACK:     if (!tx_done) state_d = S_TX_WAIT;
      S_TX_WAIT:    if (tx_done) state_d = S_FLUSH_WAIT;
      S_FLUSH: begin
        rx_reset_d = 1'b1;
        state_d    = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: if (rx_count == 16'd0) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= '0;
      rx_count_q   <= '0;
      op_q         <= '0;
      data_q       <= '0;
      status_q     <= '0;
      rx_reset_q   <= 1'b0;
      tx_bytes_q   <= '0;
      tx_size_q    <= '0;
      tx_go_q      <= 1'b0;
      freq_q       <= '0;
      phase_q      <= '0;
      ampl_q       <= DEFAULT_AMPL;
      wave_q       <= '0;
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      rx_count_q   <= rx_count_d;
      op_q         <= op_d;
      data_q       <= data_d;
      status_q     <= status_d;
      rx_reset_q   <= rx_reset_d;
      tx_bytes_q   <= tx_bytes_d;
      tx_size_q    <= tx_size_d;
      tx_go_q      <= tx_go_d;
      freq_q       <= freq_d;
      phase_q      <= phase_d;
      ampl_q       <= ampl_d;
      wave_q       <= wave_d;
      cfg_update_q <= cfg_update_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign rx_reset   = rx_reset_q;
  assign tx_bytes   = tx_bytes_q;
  assign tx_size    = tx_size_q;
  assign tx_go      = tx_go_q;
  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign ampl       = ampl_q;
  assign wave_sel   = wave_q;
  assign cfg_update = cfg_update_q;
  assign busy       = busy_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: a behavioural UART drives packets and a
// scoreboard compares each transmitted response against the bench's own model.
module tb_uart_cmd_ctrl;

  localparam int RXN = 16;
  localparam int TXN = 8;
  localparam int TMO = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*RXN-1:0] rx_bytes = '0;
  logic [15:0]     rx_count = '0;
  logic            rx_full = 1'b0;
  logic            rx_reset;
  logic [8*TXN-1:0] tx_bytes;
  logic [15:0]     tx_size;
  logic            tx_go;
  logic            tx_done = 1'b1;
  logic [31:0]     freq_word, phase_word;
  logic [15:0]     ampl;
  logic [1:0]      wave_sel;
  logic            cfg_update, busy;
  logic [7:0]      err_count;

  uart_cmd_ctrl #(
    .RX_PACKET_SIZE(RXN), .TX_PACKET_SIZE(TXN),
    .TIMEOUT_CYCLES(TMO), .DEFAULT_AMPL(16'hFFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_bytes(rx_bytes), .rx_count(rx_count),
    .rx_full(rx_full), .rx_reset(rx_reset), .tx_bytes(tx_bytes), .tx_size(tx_size),
    .tx_go(tx_go), .tx_done(tx_done), .freq_word(freq_word), .phase_word(phase_word),
    .ampl(ampl), .wave_sel(wave_sel), .cfg_update(cfg_update), .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      size;
    logic [8*TXN-1:0] bytes;
  } resp_t;

  resp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_rx_reset = 0;
  int n_tx_go = 0;
  int n_cfg = 0;
  int tx_busy_cnt = 0;
  logic rx_reset_prev = 1'b0;
  logic tx_go_prev = 1'b0;
  logic cfg_prev = 1'b0;

  logic [31:0] m_freq = '0;
  logic [31:0] m_phase = '0;
  logic [15:0] m_ampl = 16'hFFFF;
  logic [1:0]  m_wave = '0;
  logic [7:0]  m_err = '0;
  int          m_cfg = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_response();
    resp_t r;
    if (exp_q.size() == 0) begin
      check("unexpected_tx", 64'(exp_q.size()), 64'd1);
    end else begin
      r = exp_q.pop_front();
      check("tx_size", 64'(tx_size), 64'(r.size));
      check("tx_bytes", 64'(tx_bytes), 64'(r.bytes));
    end
  endtask

  // One clock of the UART model: flush on rx_reset rise, accept tx_go rise, finish TX later.
  task automatic step();
    @(posedge clk);
    #1;
    check("tx_go_width", 64'(tx_go & tx_go_prev), 64'd0);
    check("rx_reset_width", 64'(rx_reset & rx_reset_prev), 64'd0);
    check("cfg_width", 64'(cfg_update & cfg_prev), 64'd0);
    if (rx_reset && !rx_reset_prev) begin
      n_rx_reset++;
      rx_count = '0;
      rx_bytes = '0;
      rx_full  = 1'b0;
    end
    if (tx_go && !tx_go_prev) begin
      n_tx_go++;
      compare_response();
      tx_done     = 1'b0;
      tx_busy_cnt = 5;
    end else if (tx_busy_cnt > 0) begin
      tx_busy_cnt--;
      if (tx_busy_cnt == 0) tx_done = 1'b1;
    end
    if (cfg_update) n_cfg++;
    rx_reset_prev = rx_reset;
    tx_go_prev    = tx_go;
    cfg_prev      = cfg_update;
  endtask

  task automatic run_to_idle(input string tag);
    int n = 0;
    step();
    while ((busy || rx_count != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check({tag, "_hang"}, 64'(busy), 64'd0);
  endtask

  task automatic load_pkt(input logic [7:0] sync, input logic [7:0] op, input logic [31:0] data,
                          input logic [7:0] chk_flip, input int extra);
    logic [7:0] b [7];
    logic [7:0] st;
    resp_t r;
    b[0] = sync; b[1] = op;
    b[2] = data[7:0]; b[3] = data[15:8]; b[4] = data[23:16]; b[5] = data[31:24];
    b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ chk_flip;
    if (sync != 8'hA5)               st = 8'h03;
    else if (chk_flip != 8'h00)      st = 8'h01;
    else if (op == 8'h00 || op > 8'h05) st = 8'h02;
    else                             st = 8'h00;
    r.bytes = '0;
    r.bytes[7:0] = 8'h5A; r.bytes[15:8] = op; r.bytes[23:16] = st;
    if (st == 8'h00 && op == 8'h05) begin
      r.size = 16'd7;
      r.bytes[55:24] = m_freq;
    end else begin
      r.size = 16'd3;
    end
    exp_q.push_back(r);
    m_cfg = 0;
    if (st == 8'h00) begin
      case (op)
        8'h01: m_freq  = data;
        8'h02: m_phase = data;
        8'h03: m_ampl  = data[15:0];
        8'h04: m_wave  = data[1:0];
        default: ;
      endcase
      if (op != 8'h05) m_cfg = 1;
    end else if (m_err != 8'hFF) begin
      m_err++;
    end
    for (int k = 0; k < 7; k++) rx_bytes[8*k +: 8] = b[k];
    for (int k = 0; k < extra; k++) rx_bytes[8*(7+k) +: 8] = 8'hC0 + 8'(k);
    rx_count = 16'(7 + extra);
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] sync, input logic [7:0] op,
                          input logic [31:0] data, input logic [7:0] chk_flip, input int extra);
    int rr0 = n_rx_reset;
    int tg0 = n_tx_go;
    int cf0 = n_cfg;
    load_pkt(sync, op, data, chk_flip, extra);
    run_to_idle(tag);
    check({tag, "_rx_reset"}, 64'(n_rx_reset - rr0), 64'd1);
    check({tag, "_tx_go"}, 64'(n_tx_go - tg0), 64'd1);
    check({tag, "_cfg"}, 64'(n_cfg - cf0), 64'(m_cfg));
    check({tag, "_freq"}, 64'(freq_word), 64'(m_freq));
    check({tag, "_phase"}, 64'(phase_word), 64'(m_phase));
    check({tag, "_ampl"}, 64'(ampl), 64'(m_ampl));
    check({tag, "_wave"}, 64'(wave_sel), 64'(m_wave));
    check({tag, "_err"}, 64'(err_count), 64'(m_err));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_freq"}, 64'(freq_word), 64'd0);
    check({tag, "_phase"}, 64'(phase_word), 64'd0);
    check({tag, "_ampl"}, 64'(ampl), 64'hFFFF);
    check({tag, "_wave"}, 64'(wave_sel), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_tx_go"}, 64'(tx_go), 64'd0);
    check({tag, "_rx_reset"}, 64'(rx_reset), 64'd0);
    check({tag, "_cfg"}, 64'(cfg_update), 64'd0);
    check({tag, "_tx_size"}, 64'(tx_size), 64'd0);
    check({tag, "_tx_bytes"}, 64'(tx_bytes), 64'd0);
  endtask

  initial begin
    int rr0, tg0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    repeat (2) step();
    check_reset_state("post_rst");

    send_pkt("freq_wr", 8'hA5, 8'h01, 32'h12345678, 8'h00, 0);
    send_pkt("ampl_badchk", 8'hA5, 8'h03, 32'h0000BEEF, 8'h40, 0);
    send_pkt("bad_sync", 8'h00, 8'h01, 32'hDEADBEEF, 8'h11, 0);
    send_pkt("read_freq", 8'hA5, 8'h05, 32'h00000000, 8'h00, 0);
    send_pkt("bad_op", 8'hA5, 8'h07, 32'h00000001, 8'h00, 0);
    send_pkt("phase_wr", 8'hA5, 8'h02, 32'hCAFE0123, 8'h00, 2);
    send_pkt("wave_wr", 8'hA5, 8'h04, 32'hFFFFFFFE, 8'h00, 0);
    send_pkt("ampl_wr", 8'hA5, 8'h03, 32'hAAAA8001, 8'h00, 0);
    send_pkt("read_freq2", 8'hA5, 8'h05, 32'h55555555, 8'h00, 1);

    // Partial packet: count change just before expiry restarts the timeout.
    rr0 = n_rx_reset;
    tg0 = n_tx_go;
    rx_bytes[23:0] = 24'h0102A5;
    rx_count = 16'd3;
    repeat (TMO - 1) step();
    check("tmo_early1", 64'(n_rx_reset - rr0), 64'd0);
    rx_count = 16'd4;
    repeat (TMO - 1) step();
    check("tmo_restart", 64'(n_rx_reset - rr0), 64'd0);
    n = 0;
    while (n_rx_reset == rr0 && n < 20) begin
      step();
      n++;
    end
    check("tmo_flush", 64'(n_rx_reset - rr0), 64'd1);
    run_to_idle("tmo");
    if (m_err != 8'hFF) m_err++;
    check("tmo_err", 64'(err_count), 64'(m_err));
    check("tmo_no_tx", 64'(n_tx_go - tg0), 64'd0);

    // Buffer-full discard, repeated until err_count saturates.
    for (int i = 0; i < 260; i++) begin
      rx_count = 16'd2;
      rx_full  = 1'b1;
      run_to_idle("full");
      if (m_err != 8'hFF) m_err++;
      if (i == 0) check("full_err", 64'(err_count), 64'(m_err));
    end
    check("err_sat", 64'(err_count), 64'hFF);
    check("full_no_tx", 64'(n_tx_go - tg0), 64'd0);

    // Reset while waiting for the transmitter to finish.
    tg0 = n_tx_go;
    load_pkt(8'hA5, 8'h03, 32'h00001234, 8'h00, 0);
    n = 0;
    while (n_tx_go == tg0 && n < 50) begin
      step();
      n++;
    end
    check("mid_tx_go", 64'(n_tx_go - tg0), 64'd1);
    step();
    step();
    check("mid_ampl", 64'(ampl), 64'h1234);
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_done = 1'b1;
    tx_busy_cnt = 0;
    rx_count = '0;
    rx_bytes = '0;
    rx_reset_prev = 1'b0;
    tx_go_prev = 1'b0;
    cfg_prev = 1'b0;
    m_freq = '0; m_phase = '0; m_ampl = 16'hFFFF; m_wave = '0; m_err = '0;
    send_pkt("after_rst", 8'hA5, 8'h01, 32'h0BADF00D, 8'h00, 0);
    send_pkt("after_rst_rd", 8'hA5, 8'h05, 32'h0, 8'h00, 0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
